// File: rtl/half_band_decim_2_if.sv
// Sample-stream bundle for the second half-band decimator: input strobe/data
// toward the filter, decimated output and status back from it.
interface half_band_decim_2_if #(
  parameter int DW = 18
);
  logic                 in_en;
  logic signed [DW-1:0] x_in;
  logic signed [DW-1:0] y_out;
  logic                 out_valid;
  logic                 sat_flag;
  logic                 overrun;
  logic                 busy;

  modport master (
    output in_en, x_in,
    input  y_out, out_valid, sat_flag, overrun, busy
  );

  modport slave (
    input  in_en, x_in,
    output y_out, out_valid, sat_flag, overrun, busy
  );
endinterface

// File: rtl/half_band_decim_2.sv
// Second-stage 11-tap half-band decimate-by-2 FIR with one shared 19x18 multiplier.
// Each odd-indexed input starts a LOAD/MAC0/MAC1/MAC2/OUT pass producing one sample.
//
//   state  | meaning
//   IDLE   | waiting for an odd-indexed input (trigger)
//   LOAD   | snapshot symmetric tap pair sums and centre tap
//   MAC0   | acc = p0*C0 + centre tap * 0.5
//   MAC1   | acc += p1*C1
//   MAC2   | acc += p2*C2, round/clip, register output (visible in OUT)
//   OUT    | out_valid/sat_flag high for this one cycle
module half_band_decim_2 #(
  parameter int                   DW = 18,
  parameter int                   CW = 18,
  parameter logic signed [CW-1:0] C0 = 18'sd2464,
  parameter logic signed [CW-1:0] C1 = -18'sd14601,
  parameter logic signed [CW-1:0] C2 = 18'sd77673
) (
  input logic                clk,
  input logic                reset,
  half_band_decim_2_if.slave bus
);

  localparam int NT = 11;
  localparam int PW = DW + 1;
  localparam int MW = PW + CW;
  localparam int AW = 40;

  localparam logic signed [AW-1:0] RND  = AW'(1) <<< (CW - 1);
  localparam logic signed [AW-1:0] YMAX = (AW'(1) <<< (DW - 1)) - AW'(1);
  localparam logic signed [AW-1:0] YMIN = -(AW'(1) <<< (DW - 1));

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MAC0,
    S_MAC1,
    S_MAC2,
    S_OUT
  } state_e;

  state_e               state_q, state_d;
  logic signed [DW-1:0] taps_q [NT];
  logic signed [DW-1:0] taps_d [NT];
  logic                 phase_q, phase_d;
  logic signed [PW-1:0] p0_q, p0_d;
  logic signed [PW-1:0] p1_q, p1_d;
  logic signed [PW-1:0] p2_q, p2_d;
  logic signed [DW-1:0] xc_q, xc_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic signed [DW-1:0] y_q, y_d;
  logic                 valid_q, valid_d;
  logic                 sat_q, sat_d;
  logic                 overrun_q, overrun_d;

  logic signed [PW-1:0] mul_a;
  logic signed [CW-1:0] mul_b;
  logic signed [MW-1:0] prod;
  logic signed [AW-1:0] mac_sum;
  logic signed [AW-1:0] y_full;
  logic                 trig;

  assign prod    = MW'(mul_a) * MW'(mul_b);
  assign mac_sum = acc_q + AW'(prod);
  assign y_full  = (mac_sum + RND) >>> CW;
  assign trig    = bus.in_en && phase_q;

  always_comb begin
    state_d   = state_q;
    taps_d    = taps_q;
    phase_d   = phase_q;
    p0_d      = p0_q;
    p1_d      = p1_q;
    p2_d      = p2_q;
    xc_d      = xc_q;
    acc_d     = acc_q;
    y_d       = y_q;
    valid_d   = 1'b0;
    sat_d     = 1'b0;
    overrun_d = overrun_q;
    mul_a     = '0;
    mul_b     = '0;

    // Samples always shift in; a trigger that finds the FSM busy is dropped.
    if (bus.in_en) begin
      taps_d[0] = bus.x_in;
      for (int i = 1; i < NT; i++) begin
        taps_d[i] = taps_q[i-1];
      end
      phase_d = ~phase_q;
      if (trig && (state_q != S_IDLE)) begin
        overrun_d = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (trig) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        p0_d    = PW'(taps_q[0]) + PW'(taps_q[10]);
        p1_d    = PW'(taps_q[2]) + PW'(taps_q[8]);
        p2_d    = PW'(taps_q[4]) + PW'(taps_q[6]);
        xc_d    = taps_q[5];
        state_d = S_MAC0;
      end
      S_MAC0: begin
        mul_a   = p0_q;
        mul_b   = C0;
        acc_d   = AW'(prod) + (AW'(xc_q) <<< (CW - 1));
        state_d = S_MAC1;
      end
      S_MAC1: begin
        mul_a   = p1_q;
        mul_b   = C1;
        acc_d   = mac_sum;
        state_d = S_MAC2;
      end
      S_MAC2: begin
        mul_a   = p2_q;
        mul_b   = C2;
        acc_d   = mac_sum;
        valid_d = 1'b1;
        if (y_full > YMAX) begin
          y_d   = YMAX[DW-1:0];
          sat_d = 1'b1;
        end else if (y_full < YMIN) begin
          y_d   = YMIN[DW-1:0];
          sat_d = 1'b1;
        end else begin
          y_d   = y_full[DW-1:0];
        end
        state_d = S_OUT;
      end
      S_OUT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      taps_q    <= '{default: '0};
      phase_q   <= 1'b0;
      p0_q      <= '0;
      p1_q      <= '0;
      p2_q      <= '0;
      xc_q      <= '0;
      acc_q     <= '0;
      y_q       <= '0;
      valid_q   <= 1'b0;
      sat_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      taps_q    <= taps_d;
      phase_q   <= phase_d;
      p0_q      <= p0_d;
      p1_q      <= p1_d;
      p2_q      <= p2_d;
      xc_q      <= xc_d;
      acc_q     <= acc_d;
      y_q       <= y_d;
      valid_q   <= valid_d;
      sat_q     <= sat_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.y_out     = y_q;
  assign bus.out_valid = valid_q;
  assign bus.sat_flag  = sat_q;
  assign bus.overrun   = overrun_q;
  assign bus.busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_half_band_decim_2.sv
// Directed bench for half_band_decim_2: DC, impulse, latency, saturation,
// overrun and mid-computation reset, with hand-computed expected outputs.
module tb_half_band_decim_2;

  logic clk = 1'b0;
  logic reset = 1'b1;

  half_band_decim_2_if bus ();

  half_band_decim_2 dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int out_y[$];
  bit out_sat[$];
  int out_cyc[$];
  int n_vec = 0;
  int n_err = 0;
  int last_in_cyc = 0;

  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      out_y.push_back(int'(bus.y_out));
      out_sat.push_back(bus.sat_flag);
      out_cyc.push_back(cyc);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, want $finish before limit");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.in_en = 1'b0;
    bus.x_in = '0;
    step();
    step();
    reset = 1'b0;
    out_y.delete();
    out_sat.delete();
    out_cyc.delete();
  endtask

  task automatic push(input int v, input int gap);
    bus.in_en = 1'b1;
    bus.x_in = 18'(v);
    @(negedge clk);
    last_in_cyc = cyc;
    step();
    bus.in_en = 1'b0;
    bus.x_in = '0;
    repeat (gap - 1) step();
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_vec++; if (bus.y_out !== 18'sd0) begin n_err++; $display("FAIL reset_y_out: got %0d want 0", bus.y_out); end
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_vec++; if (bus.sat_flag !== 1'b0) begin n_err++; $display("FAIL reset_sat_flag: got %b want 0", bus.sat_flag); end
    n_vec++; if (bus.overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun: got %b want 0", bus.overrun); end
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    step();
  endtask

  task automatic test_dc();
    do_reset();
    for (int i = 0; i < 24; i++) push(1000, 4);
    repeat (8) step();
    n_vec++; if (out_y.size() != 12) begin n_err++; $display("FAIL dc_count: got %0d want 12", out_y.size()); end
    for (int i = 5; i < out_y.size(); i++) begin
      n_vec++;
      if (out_y[i] !== 1000 || out_sat[i] !== 1'b0) begin
        n_err++; $display("FAIL dc_out[%0d]: got %0d sat %b want 1000 sat 0", i, out_y[i], out_sat[i]);
      end
    end
  endtask

  task automatic test_impulse();
    int exp1 [8] = '{940, -5570, 29630, 29630, -5570, 940, 0, 0};
    int exp0 [7] = '{0, 0, 50000, 0, 0, 0, 0};
    do_reset();
    for (int i = 0; i < 16; i++) push((i == 1) ? 100000 : 0, 4);
    repeat (8) step();
    n_vec++; if (out_y.size() != 8) begin n_err++; $display("FAIL imp1_count: got %0d want 8", out_y.size()); end
    for (int i = 0; i < 8 && i < out_y.size(); i++) begin
      n_vec++;
      if (out_y[i] !== exp1[i]) begin n_err++; $display("FAIL imp1_out[%0d]: got %0d want %0d", i, out_y[i], exp1[i]); end
    end
    do_reset();
    for (int i = 0; i < 14; i++) push((i == 0) ? 100000 : 0, 4);
    repeat (8) step();
    n_vec++; if (out_y.size() != 7) begin n_err++; $display("FAIL imp0_count: got %0d want 7", out_y.size()); end
    for (int i = 0; i < 7 && i < out_y.size(); i++) begin
      n_vec++;
      if (out_y[i] !== exp0[i]) begin n_err++; $display("FAIL imp0_out[%0d]: got %0d want %0d", i, out_y[i], exp0[i]); end
    end
  endtask

  task automatic test_latency();
    int t1;
    do_reset();
    push(0, 6);
    n_vec++; if (out_y.size() != 0) begin n_err++; $display("FAIL lat_even_pulse: got %0d pulses want 0", out_y.size()); end
    push(100000, 1);
    t1 = last_in_cyc;
    repeat (12) step();
    n_vec++; if (out_y.size() != 1) begin n_err++; $display("FAIL lat_count: got %0d want 1", out_y.size()); end
    if (out_y.size() >= 1) begin
      n_vec++; if (out_cyc[0] !== t1 + 5) begin n_err++; $display("FAIL lat_cycle: got %0d want %0d", out_cyc[0] - t1, 5); end
      n_vec++; if (out_y[0] !== 940) begin n_err++; $display("FAIL lat_value: got %0d want 940", out_y[0]); end
    end
    @(negedge clk);
    n_vec++; if (bus.y_out !== 18'sd940 || bus.out_valid !== 1'b0) begin
      n_err++; $display("FAIL lat_hold: got y %0d valid %b want y 940 valid 0", bus.y_out, bus.out_valid);
    end
    step();
  endtask

  task automatic test_saturation();
    int vpos [11] = '{131071, 0, -131072, 0, 131071, 131071, 131071, 0, -131072, 0, 131071};
    int vneg [11];
    for (int k = 0; k < 11; k++) vneg[k] = (vpos[k] == 131071) ? -131072 : ((vpos[k] == -131072) ? 131071 : 0);
    do_reset();
    push(0, 4);
    for (int i = 1; i < 12; i++) push(vpos[11-i], 4);
    repeat (8) step();
    n_vec++; if (out_y.size() != 6) begin n_err++; $display("FAIL satp_count: got %0d want 6", out_y.size()); end
    if (out_y.size() >= 6) begin
      n_vec++; if (out_y[5] !== 131071 || out_sat[5] !== 1'b1) begin
        n_err++; $display("FAIL satp_out: got %0d sat %b want 131071 sat 1", out_y[5], out_sat[5]);
      end
    end
    do_reset();
    push(0, 4);
    for (int i = 1; i < 12; i++) push(vneg[11-i], 4);
    repeat (8) step();
    n_vec++; if (out_y.size() != 6) begin n_err++; $display("FAIL satn_count: got %0d want 6", out_y.size()); end
    if (out_y.size() >= 6) begin
      n_vec++; if (out_y[5] !== -131072 || out_sat[5] !== 1'b1) begin
        n_err++; $display("FAIL satn_out: got %0d sat %b want -131072 sat 1", out_y[5], out_sat[5]);
      end
    end
  endtask

  task automatic test_overrun();
    int t1;
    do_reset();
    push(0, 1);
    push(100000, 1);
    t1 = last_in_cyc;
    for (int i = 0; i < 10; i++) push(0, 1);
    repeat (10) step();
    @(negedge clk);
    n_vec++; if (bus.overrun !== 1'b1) begin n_err++; $display("FAIL ovr_flag: got %b want 1", bus.overrun); end
    n_vec++; if (out_y.size() != 2) begin n_err++; $display("FAIL ovr_count: got %0d want 2", out_y.size()); end
    if (out_y.size() >= 2) begin
      n_vec++; if (out_y[0] !== 940) begin n_err++; $display("FAIL ovr_first: got %0d want 940", out_y[0]); end
      n_vec++; if (out_cyc[0] !== t1 + 5) begin n_err++; $display("FAIL ovr_latency: got %0d want 5", out_cyc[0] - t1); end
      n_vec++; if (out_y[1] !== 29630) begin n_err++; $display("FAIL ovr_second: got %0d want 29630", out_y[1]); end
    end
    repeat (5) step();
    @(negedge clk);
    n_vec++; if (bus.overrun !== 1'b1) begin n_err++; $display("FAIL ovr_sticky: got %b want 1", bus.overrun); end
    step();
  endtask

  task automatic test_nontrigger_busy();
    do_reset();
    push(0, 4);
    push(100000, 2);
    push(0, 6);
    push(0, 4);
    repeat (8) step();
    @(negedge clk);
    n_vec++; if (bus.overrun !== 1'b0) begin n_err++; $display("FAIL ntb_overrun: got %b want 0", bus.overrun); end
    n_vec++; if (out_y.size() != 2) begin n_err++; $display("FAIL ntb_count: got %0d want 2", out_y.size()); end
    if (out_y.size() >= 2) begin
      n_vec++; if (out_y[0] !== 940 || out_y[1] !== -5570) begin
        n_err++; $display("FAIL ntb_values: got %0d,%0d want 940,-5570", out_y[0], out_y[1]);
      end
    end
    step();
  endtask

  task automatic test_reset_mid();
    int t1;
    do_reset();
    push(0, 4);
    push(100000, 8);
    push(0, 4);
    push(7, 1);
    push(0, 1);
    push(0, 1);
    @(negedge clk);
    n_vec++; if (bus.busy !== 1'b1 || bus.overrun !== 1'b1 || bus.y_out !== 18'sd940) begin
      n_err++; $display("FAIL rmid_pre: got busy %b ovr %b y %0d want busy 1 ovr 1 y 940", bus.busy, bus.overrun, bus.y_out);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    n_vec++; if (bus.y_out !== 18'sd0) begin n_err++; $display("FAIL rmid_y_out: got %0d want 0", bus.y_out); end
    n_vec++; if (bus.overrun !== 1'b0) begin n_err++; $display("FAIL rmid_overrun: got %b want 0", bus.overrun); end
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rmid_busy: got %b want 0", bus.busy); end
    out_y.delete();
    out_sat.delete();
    out_cyc.delete();
    repeat (8) step();
    n_vec++; if (out_y.size() != 0) begin n_err++; $display("FAIL rmid_no_pulse: got %0d pulses want 0", out_y.size()); end
    push(0, 4);
    push(100000, 4);
    t1 = last_in_cyc;
    repeat (8) step();
    n_vec++; if (out_y.size() != 1) begin n_err++; $display("FAIL rmid_after_count: got %0d want 1", out_y.size()); end
    if (out_y.size() >= 1) begin
      n_vec++; if (out_y[0] !== 940 || out_cyc[0] !== t1 + 5) begin
        n_err++; $display("FAIL rmid_after: got y %0d lat %0d want y 940 lat 5", out_y[0], out_cyc[0] - t1);
      end
    end
  endtask

  initial begin
    bus.in_en = 1'b0;
    bus.x_in = '0;
    test_reset();
    test_dc();
    test_impulse();
    test_latency();
    test_saturation();
    test_overrun();
    test_nontrigger_busy();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
